// File: rtl/fifo_wr_arb_pkg.sv
// Shared types for the FIFO write arbiter: FSM state encoding and stall counter width.
package fifo_wr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    FLUSH  = 2'd2
  } arb_state_t;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/fifo_wr_arb_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
module rr_picker #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            any_vld
);

  int idx;

  // Scan from the far end back to ptr so the last hit is the closest one.
  always_comb begin
    winner = '0;
    idx    = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NREQ;
      if (req[idx]) winner = IW'(idx);
    end
  end

  assign any_vld = |req;

endmodule

// File: rtl/fifo_wr_arb.sv
// Burst-locked round-robin write arbiter into one FIFO; one arbitration cycle per burst, beats pass through combinationally.
// fifo_full stalls the owner only; optional stall counter under FIFO_WR_ARB_STATS_EN.
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter type T    = logic [7:0],
  parameter int  NREQ = 4
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_last,
  input  T                        req_data [NREQ],
  output logic [NREQ-1:0]         req_ready,
  input  logic                    flush_req,
  output logic                    flush_done,
  input  logic                    fifo_full,
  output logic                    fifo_wen,
  output T                        fifo_wdata,
  output logic                    fifo_clear,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0]  stall_cycles
`endif
);

  localparam int IW = $clog2(NREQ);

  arb_state_t    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] winner;
  logic [IW-1:0] next_ptr;
  logic          any_vld;
  logic          flush_pend;
  logic          accept;
  logic          last_acc;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .winner  (winner),
    .any_vld (any_vld)
  );

  assign accept   = (state == LOCKED) && req_valid[grant_id] && !fifo_full;
  assign last_acc = accept && req_last[grant_id];
  assign next_ptr = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      flush_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_req) begin
            state <= FLUSH;
          end else if (any_vld) begin
            grant_id <= winner;
            state    <= LOCKED;
          end
        end
        LOCKED: begin
          if (flush_req) flush_pend <= 1'b1;
          // A flush arriving on the closing beat still lands right after it.
          if (last_acc) begin
            rr_ptr <= next_ptr;
            state  <= (flush_pend || flush_req) ? FLUSH : IDLE;
          end
        end
        FLUSH: begin
          flush_pend <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from state, so the async reset of state zeroes them immediately.
  always_comb begin
    req_ready  = '0;
    fifo_wdata = '0;
    if (state == LOCKED) begin
      req_ready[grant_id] = !fifo_full;
      if (accept) fifo_wdata = req_data[grant_id];
    end
  end

  assign fifo_wen   = accept;
  assign fifo_clear = (state == FLUSH);
  assign flush_done = (state == FLUSH);
  assign busy       = (state != IDLE);

`ifdef FIFO_WR_ARB_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles <= '0;
    end else if (state == FLUSH) begin
      stall_cycles <= '0;
    end else if ((state == LOCKED) && req_valid[grant_id] && fifo_full && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: per-requester beat queues drive the DUT, a negedge monitor scores writes and flushes.
module tb_fifo_wr_arb;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } beat_t;

  typedef struct {
    bit         flush;
    int         gid;
    logic [7:0] d;
  } exp_t;

  logic       CLK;
  logic       nRST;
  logic [3:0] req_valid;
  logic [3:0] req_last;
  logic [7:0] req_data [4];
  logic [3:0] req_ready;
  logic       flush_req;
  logic       flush_done;
  logic       fifo_full;
  logic       fifo_wen;
  logic [7:0] fifo_wdata;
  logic       fifo_clear;
  logic [1:0] grant_id;
  logic       busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stall_cycles;
`endif

  fifo_wr_arb #(.T(logic [7:0]), .NREQ(4)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .fifo_full  (fifo_full),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .fifo_clear (fifo_clear),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  int    nvec = 0;
  int    nerr = 0;
  int    cyc  = 0;
  beat_t rq [4][$];
  exp_t  exp_q [$];
  int    wr_cyc [$];
  logic [3:0] acc;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic void push_wr(input int g, input logic [7:0] d);
    exp_t e;
    e.flush = 1'b0;
    e.gid   = g;
    e.d     = d;
    exp_q.push_back(e);
  endfunction

  function automatic void push_flush();
    exp_t e;
    e.flush = 1'b1;
    e.gid   = 0;
    e.d     = 8'h00;
    exp_q.push_back(e);
  endfunction

  function automatic void load(input int r, input logic [7:0] d, input logic last);
    beat_t b;
    b.d    = d;
    b.last = last;
    rq[r].push_back(b);
  endfunction

  task automatic drive_heads();
    for (int r = 0; r < 4; r++) begin
      if (rq[r].size() > 0) begin
        req_valid[r] = 1'b1;
        req_data[r]  = rq[r][0].d;
        req_last[r]  = rq[r][0].last;
      end else begin
        req_valid[r] = 1'b0;
        req_data[r]  = 8'h00;
        req_last[r]  = 1'b0;
      end
    end
  endtask

  // Requester driver: handshake is judged on the stable pre-edge values, queues advance after the edge.
  initial begin
    acc = '0;
    forever begin
      @(negedge CLK);
      acc = req_valid & req_ready;
      @(posedge CLK);
      #1;
      for (int r = 0; r < 4; r++)
        if (acc[r] && rq[r].size() > 0) void'(rq[r].pop_front());
      drive_heads();
    end
  end

  // Monitor: every write or clear the DUT presents must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      cyc++;
      if (nRST && (fifo_wen || fifo_clear)) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_event: got wen=%0d clear=%0d required none", fifo_wen, fifo_clear);
        end else begin
          e = exp_q.pop_front();
          chk("event_is_flush", 32'(fifo_clear), 32'(e.flush));
          if (e.flush) begin
            chk("flush_done", 32'(flush_done), 32'd1);
            chk("flush_wen", 32'(fifo_wen), 32'd0);
            chk("flush_ready", 32'(req_ready), 32'd0);
          end else begin
            chk("wr_grant", 32'(grant_id), 32'(e.gid));
            chk("wr_data", 32'(fifo_wdata), 32'(e.d));
            chk("wr_ready_onehot", 32'(req_ready), 32'(1 << e.gid));
            wr_cyc.push_back(cyc);
          end
        end
      end
    end
  end

  function automatic bit all_done();
    bit q_empty = 1'b1;
    for (int r = 0; r < 4; r++) if (rq[r].size() != 0) q_empty = 1'b0;
    return q_empty && (exp_q.size() == 0) && !busy;
  endfunction

  task automatic wait_done(input string nm);
    int n = 0;
    do begin
      @(negedge CLK);
      #1;
      n++;
    end while (!all_done() && n < 300);
    nvec++;
    if (!all_done()) begin
      nerr++;
      $display("FAIL %s_timeout: got %0d pending expectations required 0", nm, exp_q.size());
    end
  endtask

  task automatic wait_wen();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!fifo_wen && n < 100);
    nvec++;
    if (!fifo_wen) begin
      nerr++;
      $display("FAIL wait_wen_timeout: got wen=0 required 1");
    end
  endtask

  initial begin
    nRST      = 1'b0;
    flush_req = 1'b0;
    fifo_full = 1'b0;
    drive_heads();
    #12;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wen", 32'(fifo_wen), 32'd0);
    chk("rst_wdata", 32'(fifo_wdata), 32'd0);
    chk("rst_clear", 32'(fifo_clear), 32'd0);
    chk("rst_done", 32'(flush_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("rst_stall", 32'(stall_cycles), 32'd0);
`endif
    @(negedge CLK);
    #1 nRST = 1'b1;
    @(negedge CLK);
    #2;

    // Round-robin over four single-beat requesters, then wrap back to 0.
    wr_cyc.delete();
    for (int r = 0; r < 4; r++) load(r, 8'(8'h10 + r), 1'b1);
    load(0, 8'h14, 1'b1);
    push_wr(0, 8'h10); push_wr(1, 8'h11); push_wr(2, 8'h12); push_wr(3, 8'h13); push_wr(0, 8'h14);
    drive_heads();
    wait_done("rr");
    chk("rr_writes", 32'(wr_cyc.size()), 32'd5);
    for (int i = 1; i < wr_cyc.size(); i++) chk("rr_gap", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd2);

    // Requester 2 holds its 3-beat burst while 1 waits; grant returns to 1 since 3 is idle.
    #2;
    load(1, 8'h20, 1'b1); load(1, 8'h24, 1'b1);
    load(2, 8'h21, 1'b0); load(2, 8'h22, 1'b0); load(2, 8'h23, 1'b1);
    push_wr(1, 8'h20); push_wr(2, 8'h21); push_wr(2, 8'h22); push_wr(2, 8'h23); push_wr(1, 8'h24);
    drive_heads();
    wait_done("lock");

    // Five-cycle full stall after the first beat of a 4-beat burst.
    #2;
    for (int i = 0; i < 4; i++) load(2, 8'(8'h30 + i), (i == 3));
    for (int i = 0; i < 4; i++) push_wr(2, 8'(8'h30 + i));
    drive_heads();
    wait_wen();
    @(posedge CLK);
    #1 fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("stall_wen", 32'(fifo_wen), 32'd0);
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_wdata", 32'(fifo_wdata), 32'd0);
      chk("stall_grant", 32'(grant_id), 32'd2);
    end
    @(posedge CLK);
    #1 fifo_full = 1'b0;
    wait_done("stall");
`ifdef FIFO_WR_ARB_STATS_EN
    chk("stall_count", 32'(stall_cycles), 32'd5);
`endif

    // Flush requested during beat 1: burst completes, then one FLUSH cycle.
    #2;
    for (int i = 0; i < 4; i++) load(3, 8'(8'h40 + i), (i == 3));
    for (int i = 0; i < 4; i++) push_wr(3, 8'(8'h40 + i));
    push_flush();
    drive_heads();
    wait_wen();
    @(posedge CLK);
    #1 flush_req = 1'b1;
    @(posedge CLK);
    #1 flush_req = 1'b0;
    wait_done("flush_pend");
    chk("post_flush_clear", 32'(fifo_clear), 32'd0);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("flush_stall_clr", 32'(stall_cycles), 32'd0);
`endif

    // In IDLE a flush beats a simultaneous request.
    #2;
    load(1, 8'h50, 1'b1);
    push_flush();
    push_wr(1, 8'h50);
    drive_heads();
    flush_req = 1'b1;
    @(posedge CLK);
    #1 flush_req = 1'b0;
    wait_done("idle_flush");

    // Reset while a beat is being offered: outputs drop at once, arbitration restarts at 0.
    #2;
    load(0, 8'h60, 1'b0); load(0, 8'h61, 1'b0); load(0, 8'h62, 1'b1);
    push_wr(0, 8'h60);
    drive_heads();
    wait_wen();
    #1 nRST = 1'b0;
    #1;
    chk("mid_rst_wen", 32'(fifo_wen), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_wdata", 32'(fifo_wdata), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_grant", 32'(grant_id), 32'd0);
    for (int r = 0; r < 4; r++) rq[r].delete();
    exp_q.delete();
    acc = '0;
    drive_heads();
    repeat (2) @(negedge CLK);
    #1 nRST = 1'b1;
    #2;
    load(3, 8'h71, 1'b1);
    load(0, 8'h70, 1'b1);
    push_wr(0, 8'h70); push_wr(3, 8'h71);
    drive_heads();
    wait_done("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
